// File: rtl/mul_div_unit.sv
// ============================================================================
// Module      : mul_div_unit
// Description : Iterative radix-2 RV32M multiply/divide unit with a
//               start/busy/done handshake and flush abort.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              start,
    input  logic [2:0]        func3,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_calc  = 2'd1;
    localparam logic [1:0] c_st_fixup = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [DATA_W-1:0] c_min = {1'b1, {(DATA_W-1){1'b0}}};

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_func3;
    logic                r_neg;
    logic [2*DATA_W-1:0] r_acc;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_result;

    // Operand decode for the launch cycle
    logic              w_is_div, w_a_signed, w_b_signed, w_a_neg, w_b_neg;
    logic              w_div_zero, w_div_ovf, w_fast, w_launch_ok, w_accept;
    logic [DATA_W-1:0] w_a_mag, w_b_mag;

    assign w_is_div    = func3[2];
    assign w_a_signed  = w_is_div ? ~func3[0] : (func3[1] ^ func3[0]);
    assign w_b_signed  = w_is_div ? ~func3[0] : (func3[1:0] == 2'b01);
    assign w_a_neg     = w_a_signed & op_a[DATA_W-1];
    assign w_b_neg     = w_b_signed & op_b[DATA_W-1];
    assign w_a_mag     = w_a_neg ? -op_a : op_a;
    assign w_b_mag     = w_b_neg ? -op_b : op_b;
    assign w_div_zero  = w_is_div && (op_b == '0);
    assign w_div_ovf   = w_is_div && !func3[0] && (op_a == c_min) && (op_b == '1);
    assign w_fast      = w_div_zero | w_div_ovf;
    assign w_launch_ok = start && !flush;
    assign w_accept    = w_launch_ok && ((r_state == c_st_idle) || (r_state == c_st_done));

    // Multiply step: conditional add into the upper half, then shift right
    logic [DATA_W:0]     w_mul_sum;
    logic [2*DATA_W-1:0] w_mul_step;
    assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} + (r_acc[0] ? {1'b0, r_b} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[DATA_W-1:1]};

    // Restoring divide step: {remainder, dividend/quotient} shifted left
    logic [DATA_W:0]     w_rs;
    logic [DATA_W-1:0]   w_rs_sub;
    logic                w_ge;
    logic [2*DATA_W-1:0] w_div_step;
    assign w_rs       = r_acc[2*DATA_W-1:DATA_W-1];
    assign w_ge       = w_rs >= {1'b0, r_b};
    assign w_rs_sub   = w_rs[DATA_W-1:0] - r_b;
    assign w_div_step = w_ge ? {w_rs_sub, r_acc[DATA_W-2:0], 1'b1}
                             : {w_rs[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0};

    // Sign correction and output selection
    logic [2*DATA_W-1:0] w_prod_fix;
    logic [DATA_W-1:0]   w_quo_fix, w_rem_fix, w_fix;
    assign w_prod_fix = r_neg ? -r_acc : r_acc;
    assign w_quo_fix  = r_neg ? -r_acc[DATA_W-1:0] : r_acc[DATA_W-1:0];
    assign w_rem_fix  = r_neg ? -r_acc[2*DATA_W-1:DATA_W] : r_acc[2*DATA_W-1:DATA_W];

    always_comb begin
        w_fix = '0;
        case (r_func3)
            3'b000:                 w_fix = w_prod_fix[DATA_W-1:0];
            3'b001, 3'b010, 3'b011: w_fix = w_prod_fix[2*DATA_W-1:DATA_W];
            3'b100, 3'b101:         w_fix = w_quo_fix;
            default:                w_fix = w_rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (w_launch_ok) w_next_state = w_fast ? c_st_fixup : c_st_calc;
            c_st_calc: begin
                if (flush)                        w_next_state = c_st_idle;
                else if (r_cnt == CNT_W'(1))      w_next_state = c_st_fixup;
            end
            c_st_fixup: w_next_state = flush ? c_st_idle : c_st_done;
            default:    w_next_state = w_launch_ok ? (w_fast ? c_st_fixup : c_st_calc) : c_st_idle;
        endcase
    end

    always_comb begin
        busy   = (r_state == c_st_calc) || (r_state == c_st_fixup);
        done   = (r_state == c_st_done);
        result = r_result;
    end

    // Fast-path operations preload the accumulator with the final quotient/remainder
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_cnt    <= '0;
            r_func3  <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_b      <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_func3 <= func3;
                r_cnt   <= CNT_W'(DATA_W);
                if (w_div_zero) begin
                    r_acc <= {op_a, {DATA_W{1'b1}}};
                    r_b   <= '0;
                    r_neg <= 1'b0;
                end else if (w_div_ovf) begin
                    r_acc <= {{DATA_W{1'b0}}, c_min};
                    r_b   <= '0;
                    r_neg <= 1'b0;
                end else if (w_is_div) begin
                    r_acc <= {{DATA_W{1'b0}}, w_a_mag};
                    r_b   <= w_b_mag;
                    r_neg <= func3[1] ? w_a_neg : (w_a_neg ^ w_b_neg);
                end else begin
                    r_acc <= {{DATA_W{1'b0}}, w_b_mag};
                    r_b   <= w_a_mag;
                    r_neg <= w_a_neg ^ w_b_neg;
                end
            end else if ((r_state == c_st_calc) && !flush) begin
                r_cnt <= r_cnt - CNT_W'(1);
                r_acc <= r_func3[2] ? w_div_step : w_mul_step;
            end
            if ((r_state == c_st_fixup) && !flush) begin
                r_result <= w_fix;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module      : tb_mul_div_unit
// Description : Self-checking bench for mul_div_unit: directed vectors,
//               handshake corner sequences and randomized model comparison.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    logic        clk;
    logic        arst_n;
    logic        start;
    logic [2:0]  func3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks;
    int errors;

    mul_div_unit #(.DATA_W(32)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .start  (start),
        .func3  (func3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Architectural reference: RV32M results computed with wide integer arithmetic
    function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        int          ia, ib;
        logic        ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ia  = $signed(a);
        ib  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'b000: begin p = ua * ub; return p[31:0]; end
            3'b001: begin p = 64'(sa * sb); return p[63:32]; end
            3'b010: begin p = 64'(sa) * ub; return p[63:32]; end
            3'b011: begin p = ua * ub; return p[63:32]; end
            3'b100: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && ((b == 0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return 34;
    endfunction

    // Called at a negedge; launches an op and waits (bounded) for done.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int bcnt);
        start = 1'b1;
        func3 = f3;
        op_a  = a;
        op_b  = b;
        @(posedge clk);
        lat  = 0;
        bcnt = 0;
        res  = '0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = n;
                res = result;
                break;
            end
        end
    endtask

    logic [31:0] res;
    int          lat, bcnt, pulses;
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          sel;

    initial begin
        checks = 0;
        errors = 0;
        arst_n = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        func3  = '0;
        op_a   = '0;
        op_b   = '0;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
        vecs[2]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[4]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'b101, 32'd100,        32'd7,         32'd14,        34};
        vecs[7]  = '{3'b111, 32'd100,        32'd7,         32'd2,         34};
        vecs[8]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 2};
        vecs[9]  = '{3'b111, 32'd5,          32'd0,         32'd5,         2};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 2};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         2};
        vecs[12] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 34};
        vecs[13] = '{3'b110, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, 2};
        vecs[14] = '{3'b000, 32'h8000_0000,  32'h8000_0000, 32'd0,         34};
        vecs[15] = '{3'b010, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34};
        vecs[16] = '{3'b101, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 34};
        vecs[17] = '{3'b100, 32'h8000_0000,  32'd1,         32'h8000_0000, 34};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_result", result, 32'd0);
        arst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, res, lat, bcnt);
            check($sformatf("vec%0d_result", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat - 1));
        end

        // Start pulse and operand changes while busy must not disturb the op
        repeat (2) @(negedge clk);
        start = 1'b1; func3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk);
        lat = 0; res = '0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 2) begin op_a = 32'd1234; op_b = 32'd1; end
            if (n == 5) begin start = 1'b1; func3 = 3'b000; op_a = 32'd9; op_b = 32'd9; end
            if (done) begin lat = n; res = result; break; end
        end
        check("ignore_start_result", res, 32'd14);
        check("ignore_start_latency", 32'(lat), 32'd34);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ignore_start_no_extra_done", 32'(pulses), 32'd0);

        // Flush during CALC at T+10
        start = 1'b1; func3 = 3'b000; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
        @(posedge clk);
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 10) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        check("flush_calc_busy", 32'(busy), 32'd0);
        check("flush_calc_done", 32'(done), 32'd0);
        check("flush_calc_result", result, 32'd14);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("flush_calc_no_done", 32'(pulses), 32'd0);
        check("flush_calc_result_held", result, 32'd14);

        // Flush during FIXUP
        start = 1'b1; func3 = 3'b111; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk);
        for (int n = 1; n <= 33; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 33) flush = 1'b1;
        end
        @(negedge clk);
        flush = 1'b0;
        check("flush_fixup_done", 32'(done), 32'd0);
        check("flush_fixup_busy", 32'(busy), 32'd0);
        check("flush_fixup_result", result, 32'd14);

        // Flush together with start while idle: nothing launches
        start = 1'b1; flush = 1'b1; func3 = 3'b101; op_a = 32'd9; op_b = 32'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush_start_busy", 32'(busy), 32'd0);

        // Back-to-back: second op launched on the done cycle of the first
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, res, lat, bcnt);
        check("b2b_first_result", res, 32'hFFFF_FFEB);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, res, lat, bcnt);
        check("b2b_second_result", res, 32'hFFFF_FFFE);
        check("b2b_second_latency", 32'(lat), 32'd34);

        // Reset asserted for one edge at T+20 of a DIV
        @(negedge clk);
        start = 1'b1; func3 = 3'b100; op_a = 32'hFFFF_FFF9; op_b = 32'd2;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (n == 20) arst_n = 1'b0;
        end
        @(negedge clk);
        arst_n = 1'b1;
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_result", result, 32'd0);
        pulses = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("midreset_no_done", 32'(pulses), 32'd0);

        // Randomized operations against the reference model
        for (int i = 0; i < 300; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = 32'd0;
            if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            if (sel == 2) rb = 32'($urandom_range(1, 15));
            if (sel == 3) ra = 32'h8000_0000;
            if (sel == 4) rb = 32'hFFFF_FFFF;
            if ($urandom_range(0, 3) == 0) repeat (2) @(negedge clk);
            run_op(rf3, ra, rb, res, lat, bcnt);
            check($sformatf("rand%0d_f%0d_%h_%h_result", i, rf3, ra, rb), res, ref_model(rf3, ra, rb));
            check($sformatf("rand%0d_latency", i), 32'(lat), 32'(exp_lat(rf3, ra, rb)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Parametrised, iterative RV32M multiply/divide unit for the basic pipeline, the successor to the single-cycle MUL ALU path.
- Executes all eight M-extension operations, selected by func3.
- Uses a start/busy/done handshake. The pipeline stalls the EX stage while busy is high.
- A flush input lets the hazard unit kill an in-flight operation.

Parameters:
DATA_W, 32, operand/result width in bits (even, >=4)
CNT_W, $clog2(DATA_W)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
arst_n  input  1  reset, synchronous, active-low (sampled on clk rising edge only)
start  input  1  launch request; accepted only when busy=0
func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  DATA_W  rs1 operand (multiplicand / dividend)
op_b  input  DATA_W  rs2 operand (multiplier / divisor)
flush  input  1  abort in-flight operation
busy  output  1  operation in progress; EX stall request
done  output  1  one-cycle pulse, result valid
result  output  DATA_W  result; held stable from done until next accepted start

Behaviour:
- Reset (arst_n=0 at clk edge):
  - State goes to IDLE.
  - busy=0, done=0, result=0.
  - All datapath registers are cleared.
  - Reset has priority over every other input, including mid-operation.
- Priority order: reset > flush > start.
- States:
  - IDLE
  - CALC
  - FIXUP
  - DONE
- IDLE:
  - When start=1, capture func3 and the operand magnitudes (two's-complement absolute value where the op treats that operand as signed).
  - Record the result sign and the counter value DATA_W.
  - Transition to CALC.
  - Fast path (division only):
    - Divide-by-zero (op_b=0) or signed overflow (DIV/REM with op_a=MIN, op_b=-1) goes to FIXUP directly, skipping CALC.
- CALC: one radix-2 step per cycle; counter decrements; on counter==1 go to FIXUP.
  - Multiply: shift-add over a 2*DATA_W product register.
  - Divide: restoring shift-subtract, producing quotient and remainder.
- FIXUP: apply sign correction and select the output, then go to DONE.
  - MUL: low DATA_W bits.
  - MULH/MULHSU/MULHU: high DATA_W bits of the signed-signed, signed-unsigned or unsigned-unsigned 2*DATA_W product.
  - DIV/DIVU: quotient truncated toward zero.
  - REM/REMU: remainder carries the sign of the dividend.
  - Divide by zero: quotient all ones; remainder = op_a.
  - Overflow: quotient = MIN (1 followed by zeros); remainder = 0.
- DONE:
  - done=1 and result is registered.
  - Same-cycle start is accepted, going to CALC or FIXUP; otherwise go to IDLE.
- Timing (start accepted at edge T):
  - Normal operations: busy=1 over cycles T+1 .. T+DATA_W+1; done=1 at cycle T+DATA_W+2 with busy=0. Latency is DATA_W+2.
  - Fast path: busy=1 at T+1 only; done at T+2.
- start with busy=1 is ignored; captured operands and func3 are unaffected by later input changes.
- flush=1 in CALC/FIXUP:
  - Next state is IDLE, busy=0, done stays 0.
  - result keeps its previous value.
- flush and start together in IDLE/DONE: flush wins; no operation launches.
- busy is a registered output (high exactly in CALC and FIXUP); done is registered.
- All arithmetic is modulo 2^DATA_W at the output; no X propagation is permitted from an unused func3.

Test Plan:
- Reset, then MUL op_a=7, op_b=0xFFFFFFFD (-3) → done at T+34, result=0xFFFFFFEB; busy high for exactly 33 cycles.
- MULH 0x80000000*0x80000000 → 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0x00000002 → 0xFFFFFFFF.
- DIV op_a=0xFFFFFFF9 (-7), op_b=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with done at T+2. DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, each at T+2.
- Back-to-back with flush:
  - Pulse start during busy → ignored.
  - Assert flush at T+10 → no done pulse, busy=0 at T+11, result unchanged.
  - Then start at the done cycle of a MUL → a new done follows exactly 34 cycles later.
- Drive arst_n=0 for one edge at T+20 of a DIV → busy=0, done=0, result=0 on the next cycle; no done pulse afterwards.
